keypad_scanner: RTL and testbench

//   Front end that produces the microwave controller's operator inputs. Scans a 4x3 matrix

---
 rtl/keypad_pkg.sv | 41 ++++
 rtl/kp_debounce.sv | 60 ++++++
 rtl/keypad_scanner.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: key codes, scan row states,
// matrix position to code mapping and digit one-hot decode.
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    StRow0,
    StRow1,
    StRow2,
    StRow3
  } scan_row_e;

  localparam key_code_t KEY_STAR = 4'd10;
  localparam key_code_t KEY_HASH = 4'd11;
  localparam key_code_t KEY_NONE = 4'd15;

  // Rows 0-2 carry digits 1-9; row 3 is '*' '0' '#'.
  function automatic key_code_t row_col_to_code(input logic [1:0] row, input logic [1:0] col);
    key_code_t code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row} << 1) + {2'b00, row} + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

  function automatic logic [9:0] code_to_onehot(input key_code_t code);
    logic [9:0] oh;
    for (int i = 0; i < 10; i++) begin
      oh[i] = (code == key_code_t'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/kp_debounce.sv
// Per-frame stability filter: a new value is accepted once it has been seen on
// DEBOUNCE_CNT consecutive enabled samples.
module kp_debounce #(
  parameter int unsigned      WIDTH        = 4,
  parameter int unsigned      DEBOUNCE_CNT = 3,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             changed_o
);

  localparam int unsigned    CntW   = (DEBOUNCE_CNT < 1) ? 1 : $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CNT);

  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             chg_q, chg_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    chg_d  = 1'b0;
    if (en_i) begin
      if (data_i == cand_q) begin
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
      end else begin
        cand_d = data_i;
        cnt_d  = CntW'(1);
      end
      if ((cnt_d == CntMax) && (cand_d != acc_q)) begin
        acc_d = cand_d;
        chg_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cand_q <= RESET_VAL;
      acc_q  <= RESET_VAL;
      cnt_q  <= '0;
      chg_q  <= 1'b0;
    end else begin
      cand_q <= cand_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      chg_q  <= chg_d;
    end
  end

  assign data_o    = acc_q;
  assign changed_o = chg_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner with debounced key code and STOP button for the microwave core.
// KEYPAD_PULSE_EN: when defined, keypad_o pulses for one cycle instead of holding the level.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned DEBOUNCE_CNT = 3
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [2:0] cols_n_i,
  input  logic       stop_btn_n_i,
  output logic [3:0] rows_n_o,
  output logic [9:0] keypad_o,
  output logic       startn_o,
  output logic       clearn_o,
  output logic       stopn_o,
  output logic       key_valid_o
);

  localparam int unsigned     DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

  localparam logic [1:0] HitsNone = 2'd0;
  localparam logic [1:0] HitsOne  = 2'd1;
  localparam logic [1:0] HitsMany = 2'd2;

  logic [2:0] cols_s1_q, cols_s2_q;
  logic       stop_s1_q, stop_s2_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cols_s1_q <= 3'b111;
      cols_s2_q <= 3'b111;
      stop_s1_q <= 1'b1;
      stop_s2_q <= 1'b1;
    end else begin
      cols_s1_q <= cols_n_i;
      cols_s2_q <= cols_s1_q;
      stop_s1_q <= stop_btn_n_i;
      stop_s2_q <= stop_s1_q;
    end
  end

  scan_row_e       row_q, row_d;
  logic [DivW-1:0] cnt_q, cnt_d;
  logic            sample, frame_end;

  assign sample    = (cnt_q == DivLast);
  assign frame_end = sample && (row_q == StRow3);

  always_comb begin
    row_d    = row_q;
    cnt_d    = sample ? '0 : cnt_q + 1'b1;
    rows_n_o = 4'b1110;
    unique case (row_q)
      StRow0: begin rows_n_o = 4'b1110; if (sample) row_d = StRow1; end
      StRow1: begin rows_n_o = 4'b1101; if (sample) row_d = StRow2; end
      StRow2: begin rows_n_o = 4'b1011; if (sample) row_d = StRow3; end
      StRow3: begin rows_n_o = 4'b0111; if (sample) row_d = StRow0; end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      row_q <= StRow0;
      cnt_q <= '0;
    end else begin
      row_q <= row_d;
      cnt_q <= cnt_d;
    end
  end

  // Frame accumulation: any frame with zero or several pressed keys reports KEY_NONE.
  logic [1:0] hits_q, hits_d, hits_acc;
  key_code_t  code_q, code_d, code_acc, frame_code;
  logic       row_one, row_many;
  logic [1:0] row_col;

  always_comb begin
    row_one  = 1'b0;
    row_many = 1'b0;
    row_col  = 2'd0;
    case (cols_s2_q)
      3'b110:  begin row_one = 1'b1; row_col = 2'd0; end
      3'b101:  begin row_one = 1'b1; row_col = 2'd1; end
      3'b011:  begin row_one = 1'b1; row_col = 2'd2; end
      3'b111:  ;
      default: row_many = 1'b1;
    endcase

    hits_acc = hits_q;
    code_acc = code_q;
    if (row_many) begin
      hits_acc = HitsMany;
    end else if (row_one) begin
      hits_acc = (hits_q == HitsNone) ? HitsOne : HitsMany;
      code_acc = row_col_to_code(row_q, row_col);
    end
    frame_code = (hits_acc == HitsOne) ? code_acc : KEY_NONE;

    hits_d = hits_q;
    code_d = code_q;
    if (frame_end) begin
      hits_d = HitsNone;
      code_d = KEY_NONE;
    end else if (sample) begin
      hits_d = hits_acc;
      code_d = code_acc;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      hits_q <= HitsNone;
      code_q <= KEY_NONE;
    end else begin
      hits_q <= hits_d;
      code_q <= code_d;
    end
  end

  key_code_t key_acc;
  logic      key_chg, stop_acc, stop_chg;

  kp_debounce #(
    .WIDTH       (4),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .RESET_VAL   (KEY_NONE)
  ) u_key_db (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .en_i     (frame_end),
    .data_i   (frame_code),
    .data_o   (key_acc),
    .changed_o(key_chg)
  );

  kp_debounce #(
    .WIDTH       (1),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .RESET_VAL   (1'b1)
  ) u_stop_db (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .en_i     (frame_end),
    .data_i   (stop_s2_q),
    .data_o   (stop_acc),
    .changed_o(stop_chg)
  );

  logic [9:0] keypad_q, keypad_d;
  logic       startn_q, startn_d, clearn_q, clearn_d, stopn_q, stopn_d;
  logic       valid_q, valid_d;

  always_comb begin
    valid_d  = key_chg && (key_acc != KEY_NONE);
`ifdef KEYPAD_PULSE_EN
    keypad_d = valid_d ? code_to_onehot(key_acc) : '0;
`else
    keypad_d = code_to_onehot(key_acc);
`endif
    startn_d = (key_acc != KEY_HASH);
    clearn_d = (key_acc != KEY_STAR);
    stopn_d  = stop_chg ? stop_acc : stopn_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      keypad_q <= '0;
      startn_q <= 1'b1;
      clearn_q <= 1'b1;
      stopn_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      keypad_q <= keypad_d;
      startn_q <= startn_d;
      clearn_q <= clearn_d;
      stopn_q  <= stopn_d;
      valid_q  <= valid_d;
    end
  end

  assign keypad_o    = keypad_q;
  assign startn_o    = startn_q;
  assign clearn_o    = clearn_q;
  assign stopn_o     = stopn_q;
  assign key_valid_o = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed bench for keypad_scanner with a frame-level reference model.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int FR = 4 * SD;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] cols_n;
  logic       stop_btn_n = 1'b1;
  logic [3:0] rows_n;
  logic [9:0] keypad;
  logic       startn, clearn, stopn, key_valid;

  logic [11:0] mask = '0;  // bit k set = key with code k held

  int checks = 0;
  int errors = 0;

  int   key_hist[$];
  int   stop_hist[$];
  int   sb[$];
  int   m_acc = 15;
  int   m_stop = 1;
  logic exp_valid = 1'b0;

  always #5 clock = ~clock;

  keypad_scanner #(
    .SCAN_DIV    (SD),
    .DEBOUNCE_CNT(DB)
  ) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .cols_n_i    (cols_n),
    .stop_btn_n_i(stop_btn_n),
    .rows_n_o    (rows_n),
    .keypad_o    (keypad),
    .startn_o    (startn),
    .clearn_o    (clearn),
    .stopn_o     (stopn),
    .key_valid_o (key_valid)
  );

  function automatic int layout(int r, int c);
    if (r < 3) return r * 3 + c + 1;
    if (c == 0) return 10;
    if (c == 1) return 0;
    return 11;
  endfunction

  // Passive matrix: a column reads low when a held key sits on a driven row.
  always_comb begin
    cols_n = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!rows_n[r] && mask[layout(r, c)]) cols_n[c] = 1'b0;
      end
    end
  end

  function automatic logic [9:0] onehot(int code);
    logic [9:0] v = '0;
    if (code >= 0 && code <= 9) v[code] = 1'b1;
    return v;
  endfunction

  function automatic int frame_code(logic [11:0] m);
    int n = 0;
    int k = 15;
    for (int i = 0; i < 12; i++) begin
      if (m[i]) begin
        n++;
        k = i;
      end
    end
    return (n == 1) ? k : 15;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    key_hist.delete();
    stop_hist.delete();
    sb.delete();
    m_acc     = 15;
    m_stop    = 1;
    exp_valid = 1'b0;
  endtask

  // A value is accepted once the last DB frames all agree on it and it differs from the current one.
  task automatic model_frame(logic [11:0] m, logic s);
    int fc = frame_code(m);
    bit same;
    exp_valid = 1'b0;
    key_hist.push_back(fc);
    if (key_hist.size() > DB) void'(key_hist.pop_front());
    same = (key_hist.size() == DB);
    foreach (key_hist[i]) if (key_hist[i] != fc) same = 0;
    if (same && fc != m_acc) begin
      m_acc = fc;
      if (fc != 15) begin
        sb.push_back(fc);
        exp_valid = 1'b1;
      end
    end
    stop_hist.push_back(int'(s));
    if (stop_hist.size() > DB) void'(stop_hist.pop_front());
    same = (stop_hist.size() == DB);
    foreach (stop_hist[i]) if (stop_hist[i] != int'(s)) same = 0;
    if (same) m_stop = int'(s);
  endtask

  task automatic check_levels();
    logic [9:0] exp_kp;
`ifdef KEYPAD_PULSE_EN
    exp_kp = exp_valid ? onehot(m_acc) : '0;
`else
    exp_kp = onehot(m_acc);
`endif
    check("keypad", int'(keypad), int'(exp_kp));
    check("startn", int'(startn), int'(m_acc != 11));
    check("clearn", int'(clearn), int'(m_acc != 10));
    check("stopn", int'(stopn), m_stop);
    check("key_valid", int'(key_valid), int'(exp_valid));
  endtask

  // Called at a negedge aligned to a frame start; returns at the negedge after the frame end.
  task automatic run_frame(logic [11:0] m, logic s);
    mask       = m;
    stop_btn_n = s;
    for (int i = 1; i <= FR; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("rows_n", int'(rows_n), int'(~(4'b0001 << ((i % FR) / SD)) & 4'hF));
      if (i == 1) check_levels();
    end
    model_frame(m, s);
  endtask

  task automatic run_frames(logic [11:0] m, logic s, int n);
    for (int i = 0; i < n; i++) run_frame(m, s);
  endtask

  function automatic logic [11:0] key_bit(int k);
    logic [11:0] v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Scoreboard monitor: every key_valid pulse must match the oldest expected acceptance.
  always @(negedge clock) begin
    if (!reset && key_valid) begin
      if (sb.size() == 0) begin
        check("kv_unexpected", 1, 0);
      end else begin
        int code;
        code = sb.pop_front();
        check("kv_keypad", int'(keypad), int'(onehot(code)));
        check("kv_startn", int'(startn), int'(code != 11));
        check("kv_clearn", int'(clearn), int'(code != 10));
      end
    end
  end

  initial begin
    logic [11:0] m;
    logic        s;
    int          sel, k1, k2, hold;

    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;

    run_frames('0, 1'b1, 3);                 // idle scan
    run_frames(key_bit(2), 1'b1, 10);        // hold '2'
    run_frames('0, 1'b1, 5);                 // release
    for (int i = 0; i < 6; i++) run_frame((i % 2 == 0) ? key_bit(5) : '0, 1'b1);
    run_frames('0, 1'b1, 3);
    run_frames(key_bit(1) | key_bit(5), 1'b1, 5);  // two keys at once
    run_frames(key_bit(11), 1'b1, 5);        // '#'
    run_frames(key_bit(10), 1'b1, 5);        // '*'
    run_frames('0, 1'b1, 4);
    run_frames(key_bit(9), 1'b0, 5);         // STOP with '9'
    run_frames(key_bit(9), 1'b1, 4);
    run_frame(key_bit(9), 1'b0);             // one-frame STOP glitch
    run_frames('0, 1'b1, 4);

    // '7' accepted, then reset in the middle of a frame
    run_frames(key_bit(7), 1'b0, 5);
    repeat (6) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("rst_keypad", int'(keypad), 0);
    check("rst_startn", int'(startn), 1);
    check("rst_clearn", int'(clearn), 1);
    check("rst_stopn", int'(stopn), 1);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_rows_n", int'(rows_n), 4'hE);
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    run_frames(key_bit(7), 1'b1, 5);
    run_frames('0, 1'b1, 4);

    for (int seg = 0; seg < 40; seg++) begin
      sel  = $urandom_range(0, 9);
      k1   = $urandom_range(0, 11);
      k2   = (k1 + $urandom_range(1, 11)) % 12;
      hold = $urandom_range(1, 5);
      s    = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      if (sel < 2) m = '0;
      else if (sel == 2) m = key_bit(k1) | key_bit(k2);
      else m = key_bit(k1);
      run_frames(m, s, hold);
    end
    run_frames('0, 1'b1, 5);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
